// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Data-memory responder for a single-cycle CPU. Behind one combinational
// read / synchronous write bus it provides a word-addressed data RAM and a
// small block of memory-mapped registers:
//
//   0x2000 .. 0x2000+4*RAM_WORDS-1  data RAM (read/write)
//   0x3000  CYCLE       free-running cycle counter, frozen once done=1 (RO)
//   0x3004  TOHOST      test-completion mailbox (WO)
//   0x3008  LOG_STATUS  {23'b0, ovf, 2'b0, full, empty, count[3:0]};
//                       a write with bit 8 set clears ovf
//   0x300C  LOG_HEAD    oldest store-log entry, 0 when empty (RO)
//   0x3010  LOG_POP     any write drops the oldest store-log entry (WO)
//
// Every RAM store also pushes its data into a store-log FIFO so a test can
// check the sequence of stores the program performed.
//
// Ports
//   clk        rising-edge clock shared with the CPU
//   reset      synchronous, active-high reset
//   MemWrite   store strobe for the current cycle
//   DataAdr    byte address; bits [1:0] are ignored
//   WriteData  store data
//   ReadData   combinational read data for DataAdr
//   done       program has written TOHOST (sticky until reset)
//   pass       TOHOST value was 1; meaningful only while done=1
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
    parameter int RAM_WORDS = 1024,
    parameter int LOG_DEPTH = 8      // power of 2, at most 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass
);

    // ------------------------------------------------------------------
    // Address map
    // ------------------------------------------------------------------
    localparam logic [31:0] RAM_BASE  = 32'h0000_2000;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    // Register addresses as word addresses (byte address >> 2).
    localparam logic [29:0] WADR_CYCLE  = 30'h0000_0C00;  // 0x3000
    localparam logic [29:0] WADR_TOHOST = 30'h0000_0C01;  // 0x3004
    localparam logic [29:0] WADR_STATUS = 30'h0000_0C02;  // 0x3008
    localparam logic [29:0] WADR_HEAD   = 30'h0000_0C03;  // 0x300C
    localparam logic [29:0] WADR_POP    = 30'h0000_0C04;  // 0x3010

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    localparam logic [3:0] COUNT_FULL = 4'(LOG_DEPTH);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0]   ram_off;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic [29:0]   word_adr;
    logic          is_tohost;
    logic          is_status;
    logic          is_pop;

    // The subtraction wraps for addresses below the RAM base, so a single
    // unsigned compare against the RAM size covers both ends of the window.
    assign ram_off  = DataAdr - RAM_BASE;
    assign ram_hit  = (ram_off < RAM_BYTES);
    assign ram_idx  = ram_off[AW+1:2];
    assign word_adr = DataAdr[31:2];

    assign is_tohost = (word_adr == WADR_TOHOST);
    assign is_status = (word_adr == WADR_STATUS);
    assign is_pop    = (word_adr == WADR_POP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   mem [RAM_WORDS];
    logic [31:0]   log_mem [LOG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    count;
    logic          ovf;
    logic [31:0]   cycle;

    logic          full;
    logic          empty;
    logic          ram_we;
    logic          push;
    logic          pop;
    logic [31:0]   log_head;
    logic [31:0]   log_status;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == 4'd0);

    // Stores are suppressed entirely while reset is held: no RAM write
    // and no log push.
    assign ram_we = MemWrite && ram_hit && !reset;
    assign push   = ram_we && !full;
    assign pop    = MemWrite && is_pop && !empty && !reset;

    assign log_head   = empty ? 32'd0 : log_mem[rd_ptr];
    assign log_status = {23'd0, ovf, 2'b00, full, empty, count};

    // Pointers wrap explicitly at LOG_DEPTH-1 rather than relying on the
    // natural binary rollover of the pointer width.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LOG_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Data RAM and log storage
    // ------------------------------------------------------------------
    // NOTE: storage arrays have no reset branch; clearing them would turn
    // the block RAM into thousands of flops. Only control state is reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            log_mem[wr_ptr] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Log FIFO control
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            // Push and pop target different addresses and can never be
            // requested in the same cycle; the equal case is still held.
            if (push && !pop) begin
                count <= count + 4'd1;
            end else if (pop && !push) begin
                count <= count - 4'd1;
            end

            if (ram_we && full) begin
                ovf <= 1'b1;
            end else if (MemWrite && is_status && WriteData[8]) begin
                ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and test-completion mailbox
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= 32'd0;
        end else if (!done) begin
            cycle <= cycle + 32'd1;
        end
    end

    // Only the first TOHOST write counts; later ones leave done/pass alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (MemWrite && is_tohost && !done) begin
            done <= 1'b1;
            pass <= (WriteData == 32'h0000_0001);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // NOTE: ReadData gets a default before any branch so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        ReadData = 32'd0;
        if (ram_hit) begin
            ReadData = mem[ram_idx];
        end else begin
            case (word_adr)
                WADR_CYCLE:  ReadData = cycle;
                WADR_STATUS: ReadData = log_status;
                WADR_HEAD:   ReadData = log_head;
                default:     ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio_responder
//
// Directed bench for dmem_mmio_responder. Inputs change on the falling edge,
// stores are captured on the following rising edge, and outputs are sampled
// 1 ns after an input change, away from the active edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_responder;

    localparam logic [31:0] A_CYCLE  = 32'h3000;
    localparam logic [31:0] A_TOHOST = 32'h3004;
    localparam logic [31:0] A_STATUS = 32'h3008;
    localparam logic [31:0] A_HEAD   = 32'h300C;
    localparam logic [31:0] A_POP    = 32'h3010;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        done;
    logic        pass;

    int total = 0;
    int bad   = 0;

    dmem_mmio_responder #(
        .RAM_WORDS (1024),
        .LOG_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read without advancing the clock.
    task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        MemWrite = 1'b0;
        DataAdr  = addr;
        #1;
        check(tag, ReadData, exp);
    endtask

    // Read in the next cycle.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        peek(addr, exp, tag);
    endtask

    // One-cycle store captured on the next rising edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    // Holds reset for n rising edges and releases it on a falling edge.
    task automatic do_reset(input int n);
        @(negedge clk);
        MemWrite = 1'b0;
        reset    = 1'b1;
        repeat (n) @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic check_flags(input logic exp_done, input logic exp_pass, input string tag);
        check({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, ".pass"}, {31'd0, pass}, {31'd0, exp_pass});
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;

        // ---------------- reset state, cycle counting ----------------
        do_reset(2);
        check_flags(1'b0, 1'b0, "rst");
        peek(A_CYCLE,  32'd0,      "rst.cycle");
        peek(A_STATUS, 32'h010,    "rst.status");
        peek(A_HEAD,   32'd0,      "rst.head");
        repeat (9) @(negedge clk);
        rd(A_CYCLE, 32'd10, "cycle.11th");

        // Unmapped / write-only reads and a store to read-only CYCLE.
        store(A_CYCLE, 32'hFFFF_0000);
        rd(A_CYCLE,      32'd12, "cycle.ro_store");
        rd(32'h1000,     32'd0,  "unmapped.1000");
        rd(A_TOHOST,     32'd0,  "wo.tohost");
        rd(A_POP,        32'd0,  "wo.pop");
        rd(32'h1FFC,     32'd0,  "unmapped.below_ram");
        rd(32'h3014,     32'd0,  "unmapped.3014");
        rd(A_STATUS,     32'h010, "status.after_ro_store");

        // ---------------- store, read back, log ----------------
        store(32'h2004, 32'h14);
        rd(32'h2004, 32'h14,  "ram.2004");
        rd(32'h2006, 32'h14,  "ram.low_bits_ignored");
        rd(A_STATUS, 32'h001, "status.count1");
        rd(A_HEAD,   32'h14,  "head.first");

        store(32'h2008, 32'h3803);
        rd(A_STATUS, 32'h002,  "status.count2");
        rd(A_HEAD,   32'h14,   "head.still_first");
        store(A_POP, 32'h0);
        rd(A_HEAD,   32'h3803, "head.after_pop1");
        store(A_POP, 32'hABCD);
        rd(A_HEAD,   32'd0,    "head.empty");
        rd(A_STATUS, 32'h010,  "status.empty");
        store(A_POP, 32'h0);
        rd(A_STATUS, 32'h010,  "status.pop_empty");
        rd(A_HEAD,   32'd0,    "head.pop_empty");
        rd(32'h2008, 32'h3803, "ram.2008");

        // ---------------- overflow ----------------
        store(32'h2FFC, 32'hA0);  // last RAM word, first log entry
        for (int i = 1; i < 9; i++) begin
            store(32'h2010 + 32'(4 * i), 32'h100 + 32'(i));
        end
        rd(A_STATUS, 32'h128, "status.ovf_full");
        rd(A_HEAD,   32'hA0,  "head.oldest_kept");
        rd(32'h2FFC, 32'hA0,  "ram.last_word");
        rd(32'h2030, 32'h108, "ram.dropped_push_still_written");
        store(A_STATUS, 32'h0FF);
        rd(A_STATUS, 32'h128, "status.ovf_kept");
        store(A_STATUS, 32'h100);
        rd(A_STATUS, 32'h028, "status.ovf_cleared");
        store(A_POP, 32'h0);
        rd(A_STATUS, 32'h007, "status.count7");
        rd(A_HEAD,   32'h101, "head.second");

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'h2004;
        WriteData = 32'hDEAD;
        @(posedge clk);
        #1;
        peek(32'h2008, 32'h3803, "rst.comb_read");
        @(negedge clk);
        reset = 1'b0;
        peek(A_STATUS, 32'h010, "rst.flush");
        peek(A_CYCLE,  32'd0,   "rst.cycle_mid");
        rd(32'h2004,   32'h14,  "rst.store_ignored");

        // ---------------- TOHOST pass, cycle freeze ----------------
        do_reset(2);
        repeat (9) @(negedge clk);
        rd(A_CYCLE, 32'd10, "cycle.10_again");
        store(A_TOHOST, 32'h1);
        check_flags(1'b1, 1'b1, "tohost1");
        rd(A_CYCLE, 32'd12, "cycle.at_done");
        repeat (3) @(negedge clk);
        rd(A_CYCLE, 32'd12, "cycle.frozen");

        // ---------------- TOHOST fail is sticky ----------------
        do_reset(1);
        check_flags(1'b0, 1'b0, "rst2");
        store(A_TOHOST, 32'h5);
        check_flags(1'b1, 1'b0, "tohost5");
        store(A_TOHOST, 32'h1);
        check_flags(1'b1, 1'b0, "tohost_sticky");
        do_reset(1);
        check_flags(1'b0, 1'b0, "rst3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
